// File: rtl/riscv_test_mem_port_if.sv
// Request/response bundle for the test memory port.
// The master issues requests and sinks responses; the memory is the slave.
interface riscv_test_mem_port_if;
  logic [66:0] memreq_msg;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [34:0] memresp_msg;
  logic        memresp_val;

  modport master (
    output memreq_msg, memreq_val,
    input  memreq_rdy, memresp_msg, memresp_val
  );

  modport slave (
    input  memreq_msg, memreq_val,
    output memreq_rdy, memresp_msg, memresp_val
  );
endinterface

// File: rtl/riscv_test_mem_port.sv
// Fully pipelined test memory with fixed LATENCY and byte-lane reads/writes.
// Define RISCV_TEST_MEM_PORT_STALL_EN to drop memreq_rdy for one cycle after every STALL_PERIOD accepts.
module riscv_test_mem_port #(
  parameter int LATENCY      = 2,
  parameter int DEPTH_LOG2   = 8,
  parameter int STALL_PERIOD = 4
) (
  input logic                   clk,
  input logic                   reset,
  riscv_test_mem_port_if.slave  bus
);
  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0] store [WORDS];

  logic                  accept;
  logic                  stall;
  logic                  req_type;
  logic [31:0]           req_addr;
  logic [1:0]            req_len;
  logic [31:0]           req_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            offset;
  logic [2:0]            nbytes;
  logic [2:0]            keep;
  logic [31:0]           word;
  logic [31:0]           word_shifted;
  logic [31:0]           data_shifted;
  logic [31:0]           rd_data;
  logic [31:0]           wr_mask;
  logic                  unused_addr_bits;

  assign {req_type, req_addr, req_len, req_data} = bus.memreq_msg;
  assign idx              = req_addr[DEPTH_LOG2+1:2];
  assign offset           = req_addr[1:0];
  assign word             = store[idx];
  assign word_shifted     = word >> {offset, 3'b000};
  assign data_shifted     = req_data << {offset, 3'b000};
  assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

  // Bytes that would spill past the word boundary are simply clipped away.
  always_comb begin
    nbytes  = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};
    keep    = nbytes;
    rd_data = '0;
    wr_mask = '0;
    if (nbytes > 3'd4 - {1'b0, offset}) begin
      keep = 3'd4 - {1'b0, offset};
    end
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < keep) begin
        rd_data[8*i +: 8] = word_shifted[8*i +: 8];
      end
      if (3'(i) >= {1'b0, offset} && 3'(i) < {1'b0, offset} + keep) begin
        wr_mask[8*i +: 8] = 8'hFF;
      end
    end
  end

  assign bus.memreq_rdy = !reset && !stall;
  assign accept         = bus.memreq_val && bus.memreq_rdy;

  always_ff @(posedge clk) begin
    if (accept && req_type) begin
      store[idx] <= (word & ~wr_mask) | (data_shifted & wr_mask);
    end
  end

  logic [LATENCY-1:0] pipe_val;
  logic [34:0]        pipe_msg [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_val <= '0;
    end else begin
      pipe_val[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_val[i] <= pipe_val[i-1];
      end
    end
  end

  // Payload needs no reset: it is only ever observed through its valid bit.
  always_ff @(posedge clk) begin
    pipe_msg[0] <= {req_type, req_len, req_type ? 32'd0 : rd_data};
    for (int i = 1; i < LATENCY; i++) begin
      pipe_msg[i] <= pipe_msg[i-1];
    end
  end

  assign bus.memresp_val = pipe_val[LATENCY-1] && !reset;
  assign bus.memresp_msg = bus.memresp_val ? pipe_msg[LATENCY-1] : 35'd0;

`ifdef RISCV_TEST_MEM_PORT_STALL_EN
  localparam int CW = $clog2(STALL_PERIOD + 1);

  logic [CW-1:0] accept_cnt;
  logic          stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      accept_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (accept) begin
        if (accept_cnt == CW'(STALL_PERIOD - 1)) begin
          accept_cnt <= '0;
          stall_q    <= 1'b1;
        end else begin
          accept_cnt <= accept_cnt + CW'(1);
        end
      end
    end
  end

  assign stall = stall_q;
`else
  logic unused_stall_period;

  assign stall               = 1'b0;
  assign unused_stall_period = STALL_PERIOD[0];
`endif
endmodule

// File: tb/tb_riscv_test_mem_port.sv
// Scoreboard bench for riscv_test_mem_port: a byte-addressed reference store predicts each response.
// Honours RISCV_TEST_MEM_PORT_STALL_EN when predicting memreq_rdy.
module tb_riscv_test_mem_port;
  localparam int LAT = 3;
  localparam int DL2 = 8;
  localparam int SP  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  riscv_test_mem_port_if mp ();

  riscv_test_mem_port #(
    .LATENCY     (LAT),
    .DEPTH_LOG2  (DL2),
    .STALL_PERIOD(SP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] msg;
    int          due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_bytes [4 << DL2];
  int         cycle     = 0;
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         acc_cnt   = 0;
  bit         stall_now = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check35(string name, logic [34:0] act, logic [34:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
  endtask

  // Reference store works on individual bytes; bytes past the word end are dropped.
  function automatic logic [31:0] model_read(logic [31:0] addr, logic [1:0] len);
    int          n    = (len == 2'd0) ? 4 : int'(len);
    int          base = int'(addr[DL2+1:0]);
    logic [31:0] r    = '0;
    for (int k = 0; k < n; k++)
      if (int'(addr[1:0]) + k < 4) r[8*k +: 8] = ref_bytes[base + k];
    return r;
  endfunction

  task automatic model_write(logic [31:0] addr, logic [1:0] len, logic [31:0] data);
    int n    = (len == 2'd0) ? 4 : int'(len);
    int base = int'(addr[DL2+1:0]);
    for (int k = 0; k < n; k++)
      if (int'(addr[1:0]) + k < 4) ref_bytes[base + k] = data[8*k +: 8];
  endtask

  task automatic checkOutput();
    exp_t e;
    if (mp.memresp_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        check35("unexpected_resp_val", 35'(mp.memresp_val), 35'd0);
      end else begin
        e = exp_q.pop_front();
        check35("resp_msg", mp.memresp_msg, e.msg);
        check35("resp_cycle", 35'(cycle), 35'(e.due));
      end
    end else begin
      check35("idle_resp_msg", mp.memresp_msg, 35'd0);
      if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
        e = exp_q.pop_front();
        check35("missing_resp_val", 35'(mp.memresp_val), 35'd1);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput();
  end

  // One bus cycle: drive at negedge, predict rdy, record any accept in the scoreboard.
  task automatic driveCycle(bit rst, bit val, logic [66:0] msg, output bit accepted);
    bit          exp_rdy;
    bit          typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    exp_t        e;
    @(negedge clk);
    reset         = rst;
    mp.memreq_val = val;
    mp.memreq_msg = msg;
    if (rst) begin
      exp_q.delete();
      acc_cnt   = 0;
      stall_now = 1'b0;
    end
    #1;
    exp_rdy = !rst && !stall_now;
    check35("memreq_rdy", 35'(mp.memreq_rdy), 35'(exp_rdy));
    accepted = val && !rst && (mp.memreq_rdy === 1'b1);
    stall_now = 1'b0;
    if (accepted) begin
      {typ, addr, len, data} = msg;
      e.due = cycle + LAT;
      e.msg = {typ, len, typ ? 32'd0 : model_read(addr, len)};
      if (typ) model_write(addr, len, data);
      exp_q.push_back(e);
      acc_cnt++;
      if (acc_cnt == SP) begin
        acc_cnt = 0;
`ifdef RISCV_TEST_MEM_PORT_STALL_EN
        stall_now = 1'b1;
`endif
      end
    end
  endtask

  task automatic applyStimulus(bit typ, logic [31:0] addr, logic [1:0] len, logic [31:0] data);
    bit acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) driveCycle(1'b0, 1'b1, {typ, addr, len, data}, acc);
    if (!acc) check35("accept_timeout", 35'(acc), 35'd1);
  endtask

  task automatic idleCycles(int n, bit rst);
    bit a;
    repeat (n) driveCycle(rst, 1'b0, 67'd0, a);
  endtask

  initial begin
    bit a;
    mp.memreq_val = 1'b0;
    mp.memreq_msg = '0;

    // Requests offered during reset must be ignored.
    for (int i = 0; i < 3; i++) driveCycle(1'b1, 1'b1, {1'b1, 32'h20, 2'd0, 32'hFFFF_FFFF}, a);

    for (int w = 0; w < (1 << DL2); w++) applyStimulus(1'b1, 32'(w * 4), 2'd0, $urandom);

    applyStimulus(1'b1, 32'h10, 2'd0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h10, 2'd0, 32'h0);
    applyStimulus(1'b1, 32'h11, 2'd1, 32'h55);
    applyStimulus(1'b0, 32'h10, 2'd0, 32'h0);
    applyStimulus(1'b0, 32'h12, 2'd2, 32'h0);

    applyStimulus(1'b1, 32'h400, 2'd0, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0, 2'd0, 32'h0);
    applyStimulus(1'b1, 32'h3, 2'd2, 32'hAABB);
    applyStimulus(1'b0, 32'h0, 2'd0, 32'h0);
    idleCycles(2, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, $urandom, 2'($urandom_range(0, 3)), 32'h0);
    idleCycles(LAT + 1, 1'b0);

    // Two reads in flight are discarded; a write offered during reset must not land.
    applyStimulus(1'b0, 32'h10, 2'd0, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'd0, 32'h0);
    driveCycle(1'b1, 1'b1, {1'b1, 32'h24, 2'd0, 32'h0BAD_F00D}, a);
    idleCycles(LAT + 1, 1'b1);
    idleCycles(1, 1'b0);
    applyStimulus(1'b0, 32'h10, 2'd0, 32'h0);
    applyStimulus(1'b0, 32'h24, 2'd0, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'd0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idleCycles(1, 1'b0);
      else applyStimulus(1'($urandom), $urandom, 2'($urandom_range(0, 3)), $urandom);
    end

    idleCycles(LAT + 3, 1'b0);
    check35("scoreboard_drained", 35'(exp_q.size()), 35'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation reached cycle %0d without finishing", cycle);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/riscv_test_mem_port.md
RISCV_TEST_MEM_PORT -- requirements
Module: riscv_test_mem_port

Interface
REQ-001 SHALL have parameter LATENCY, default 2; cycles from request accept to response valid; legal range 1..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8; backing store holds 2^DEPTH_LOG2 32-bit words.
REQ-003 SHALL have parameter STALL_PERIOD, default 4; backpressure period, used only under REQ-024.
REQ-004 SHALL have port clk, input, 1 bit; sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-006 SHALL have port memreq_msg, input, 67 bits: [66] type (0 read, 1 write), [65:34] addr, [33:32] len, [31:0] data.
REQ-007 SHALL have port memreq_val, input, 1 bit; request valid.
REQ-008 SHALL have port memreq_rdy, output, 1 bit; request accepted when val && rdy at a rising edge.
REQ-009 SHALL have port memresp_msg, output, 35 bits: [34] type, [33:32] len, [31:0] data.
REQ-010 SHALL have port memresp_val, output, 1 bit; response valid; no response ready exists, so the consumer always sinks it.

Function
REQ-011 SHALL accept at most one request per cycle, fully pipelined; back-to-back accepts yield back-to-back responses.
REQ-012 SHALL assert memresp_val exactly LATENCY cycles after the accepting edge, one response per accepted request, in accept order.
REQ-013 SHALL echo the request type and len in the response.
REQ-014 SHALL index the word as addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses wrap modulo the store size.
REQ-015 SHALL decode len as a byte count: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = 3 bytes; the first byte lane is addr[1:0].
REQ-016 SHALL drop, silently, any bytes of an access that fall past the word boundary; no fault is raised.
REQ-017 SHALL, on a write, update only the addressed byte lanes from data[7:0] upward at the accepting edge; the write response data SHALL be 0.
REQ-018 SHALL, on a read, sample the store at the accepting edge, right-align the selected bytes, and zero-extend them into the response data.
REQ-019 SHALL let a read accepted in the cycle after a write to the same word observe the written bytes.
REQ-020 SHALL hold memreq_rdy = 1 in every non-reset cycle unless REQ-024 applies.
REQ-021 SHALL set memresp_msg to 0 whenever memresp_val = 0.

Reset
REQ-022 SHALL, while reset = 1, drive memreq_rdy = 0 and memresp_val = 0 and clear every pipeline valid bit; requests presented during reset are not accepted.
REQ-023 SHALL discard in-flight responses when reset is asserted mid-operation; the store contents SHALL NOT be cleared by reset.

Configuration
REQ-024 SHALL, with RISCV_TEST_MEM_PORT_STALL_EN defined, count accepted requests modulo STALL_PERIOD; after every STALL_PERIOD-th accept, memreq_rdy SHALL be 0 for exactly one cycle and the counter SHALL reset to 0. Reset clears the counter.
REQ-025 SHALL, with RISCV_TEST_MEM_PORT_STALL_EN undefined, contain no stall counter, and memreq_rdy SHALL follow REQ-020 unconditionally.

Verification
REQ-026 SHALL cover a full-word round trip: write addr 0x10 data 0xDEADBEEF len 0, then read 0x10 len 0 on the next cycle -> write response data 0 at accept+2, read response data 0xDEADBEEF at accept+2 (LATENCY = 2).
REQ-027 SHALL cover a byte write then read: after REQ-026, write addr 0x11 len 1 data 0x55, then read addr 0x10 len 0 -> 0xDEAD55EF; read addr 0x12 len 2 -> 0x0000DEAD.
REQ-028 SHALL cover wrap and truncation: write addr 0x400 len 0 data 0x12345678 with DEPTH_LOG2 = 8 -> read addr 0x0 returns 0x12345678; write addr 0x3 len 2 data 0xAABB -> read addr 0x0 returns 0xBB345678.
REQ-029 SHALL cover streaming and reset: 8 back-to-back reads with LATENCY = 3 -> 8 consecutive memresp_val cycles in order; assert reset with 2 responses in flight -> no memresp_val after reset, store unchanged.
REQ-030 SHALL cover backpressure with RISCV_TEST_MEM_PORT_STALL_EN defined and STALL_PERIOD = 4: continuous val -> memreq_rdy pattern 1,1,1,1,0 repeating, and all accepted responses are correct.
